// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and helpers for the extended-Hamming encode path.
package hamming_pkg;

  localparam int M_MAX = 4;
  localparam int N_MAX = (1 << M_MAX) - 1;
  localparam int K_MAX = N_MAX - M_MAX;
  localparam int CW    = 1 << M_MAX;
  localparam int NW    = $clog2(N_MAX + 1);
  localparam int MW    = $clog2(M_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_READY,
    S_ENCODE,
    S_OUTPUT
  } state_e;

  // Candidate columns that are powers of two are the parity positions, not data rows.
  function automatic logic is_pow2(input logic [NW-1:0] v);
    return (v != '0) && ((v & (v - NW'(1))) == '0);
  endfunction

endpackage

// File: rtl/hamming_encode_scheduler_if.sv
// Configuration, request and codeword-output bundle of the encode scheduler.
interface hamming_encode_scheduler_if;
  import hamming_pkg::*;

  logic                 cfg_valid;
  logic [MW-1:0]        cfg_m;
  logic                 cfg_ready;
  logic                 cfg_err;
  logic                 cfg_done;
  logic [NW-1:0]        n_o;
  logic [NW-1:0]        k_o;
  logic [1:0]           req_valid;
  logic [2*K_MAX-1:0]   req_msg;
  logic [1:0]           req_ready;
  logic                 out_valid;
  logic [CW-1:0]        out_code;
  logic                 out_id;
  logic                 out_ready;

  modport slave (
    input  cfg_valid, cfg_m, req_valid, req_msg, out_ready,
    output cfg_ready, cfg_err, cfg_done, n_o, k_o, req_ready,
           out_valid, out_code, out_id
  );

  modport master (
    output cfg_valid, cfg_m, req_valid, req_msg, out_ready,
    input  cfg_ready, cfg_err, cfg_done, n_o, k_o, req_ready,
           out_valid, out_code, out_id
  );

endinterface

// File: rtl/hamming_row_gen.sv
// Maps a column candidate c to one systematic generator row: data identity bit,
// the m bits of c (MSB first) as parity bits, then the overall even-parity bit.
module hamming_row_gen
  import hamming_pkg::*;
(
  input  logic [NW-1:0] c_i,
  input  logic [MW-1:0] m_i,
  input  logic [NW-1:0] k_i,
  input  logic [NW-1:0] r_i,
  output logic [CW-1:0] row_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] row;
  logic [NW-1:0] c_bits;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    c_bits = '0;
    row    = ONE << r_i;
    for (int j = 0; j < M_MAX; j++) begin
      if (j < int'(m_i)) begin
        c_bits = c_i >> (int'(m_i) - 1 - j);
        if (c_bits[0]) row = row | (ONE << (int'(k_i) + j));
      end
    end
    row   = row | (CW'(^row) << (int'(k_i) + int'(m_i)));
    row_o = row;
  end

endmodule

// File: rtl/hamming_encode_scheduler.sv
// Builds the generator table for the configured m, then arbitrates two requesters
// round-robin and encodes one message at a time, one generator row per cycle.
module hamming_encode_scheduler
  import hamming_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  hamming_encode_scheduler_if.slave bus
);

  state_e           state_q, state_d;
  logic [MW-1:0]    m_q;
  logic [NW-1:0]    n_q, k_q, c_q, r_q, j_q;
  logic [CW-1:0]    table_q [K_MAX];
  logic [CW-1:0]    acc_q;
  logic [K_MAX-1:0] msg_q;
  logic             rr_q, id_q, gap_q;

  logic             cfg_open, cfg_fire, cfg_legal, cfg_accept;
  logic             grant, grant_id, build_last, encode_last;
  logic [NW-1:0]    n_new, k_new;
  logic [K_MAX-1:0] k_mask, msg_sel;
  logic [CW-1:0]    row_w;

  hamming_row_gen u_row_gen (
    .c_i   (c_q),
    .m_i   (m_q),
    .k_i   (k_q),
    .r_i   (r_q),
    .row_o (row_w)
  );

  assign cfg_open   = !reset && (state_q == S_IDLE || state_q == S_READY);
  assign cfg_fire   = bus.cfg_valid && cfg_open;
  assign cfg_legal  = (bus.cfg_m >= MW'(2)) && (bus.cfg_m <= MW'(M_MAX));
  assign cfg_accept = cfg_fire && cfg_legal;
  assign n_new      = NW'((1 << bus.cfg_m) - 1);
  assign k_new      = n_new - NW'(bus.cfg_m);

  // gap_q holds off arbitration for the first READY cycle after a codeword leaves.
  assign grant      = (state_q == S_READY) && !bus.cfg_valid && !gap_q && (|bus.req_valid);
  assign grant_id   = bus.req_valid[rr_q] ? rr_q : ~rr_q;
  assign k_mask     = K_MAX'((1 << k_q) - 1);
  assign msg_sel    = (grant_id ? bus.req_msg[2*K_MAX-1:K_MAX] : bus.req_msg[K_MAX-1:0]) & k_mask;

  assign build_last  = (c_q == n_q);
  assign encode_last = (j_q == k_q - NW'(1));

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_accept) state_d = S_BUILD;
      S_BUILD:  if (build_last) state_d = S_READY;
      S_READY: begin
        if (cfg_accept) state_d = S_BUILD;
        else if (grant) state_d = S_ENCODE;
      end
      S_ENCODE: if (encode_last) state_d = S_OUTPUT;
      S_OUTPUT: if (bus.out_ready) state_d = S_READY;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ready = cfg_open;
    bus.cfg_err   = cfg_fire && !cfg_legal;
    bus.cfg_done  = state_q inside {S_READY, S_ENCODE, S_OUTPUT};
    bus.n_o       = n_q;
    bus.k_o       = k_q;
    bus.req_ready = '0;
    if (grant) bus.req_ready[grant_id] = 1'b1;
    bus.out_valid = (state_q == S_OUTPUT);
    bus.out_code  = (state_q == S_OUTPUT) ? acc_q : '0;
    bus.out_id    = (state_q == S_OUTPUT) && id_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q   <= '0;
      n_q   <= '0;
      k_q   <= '0;
      c_q   <= '0;
      r_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
      msg_q <= '0;
      rr_q  <= 1'b0;
      id_q  <= 1'b0;
      gap_q <= 1'b0;
      // NOTE: the table is a small flop array that must read as empty after reset,
      // so it is cleared here rather than left to a RAM with undefined contents.
      for (int i = 0; i < K_MAX; i++) table_q[i] <= '0;
    end else begin
      gap_q <= (state_q == S_OUTPUT) && bus.out_ready;

      if (cfg_accept) begin
        m_q <= bus.cfg_m;
        n_q <= n_new;
        k_q <= k_new;
        c_q <= NW'(1);
        r_q <= '0;
        for (int i = 0; i < K_MAX; i++) table_q[i] <= '0;
      end

      if (state_q == S_BUILD) begin
        c_q <= c_q + NW'(1);
        if (!is_pow2(c_q)) begin
          table_q[r_q] <= row_w;
          r_q          <= r_q + NW'(1);
        end
      end

      if (grant) begin
        msg_q <= msg_sel;
        id_q  <= grant_id;
        rr_q  <= ~grant_id;
        acc_q <= '0;
        j_q   <= '0;
      end

      if (state_q == S_ENCODE) begin
        if (msg_q[j_q]) acc_q <= acc_q ^ table_q[j_q];
        j_q <= j_q + NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_encode_scheduler.sv
// Table-driven bench for hamming_encode_scheduler with a codeword scoreboard.
module tb_hamming_encode_scheduler;
  import hamming_pkg::*;

  typedef struct {
    logic [MW-1:0]    m;
    logic             id;
    logic [K_MAX-1:0] msg;
    logic [CW-1:0]    code;
  } vec_t;

  typedef struct {
    logic          id;
    logic [CW-1:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs [14];

  hamming_encode_scheduler_if bus ();

  hamming_encode_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Moves into the input-drive window just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_config(input logic [MW-1:0] m, input bit legal);
    int n_exp, k_exp, cyc;
    n_exp = (1 << m) - 1;
    k_exp = n_exp - int'(m);
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_m     = m;
    @(negedge clk);
    check("cfg_ready_at_handshake", bus.cfg_ready, 1);
    check("cfg_err_at_handshake", bus.cfg_err, !legal);
    step();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    if (legal) begin
      cyc = 1;
      check("cfg_done_low_in_build", bus.cfg_done, 0);
      while (!bus.cfg_done && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("cfg_done_latency", cyc, n_exp + 1);
      check("n_o", bus.n_o, n_exp);
      check("k_o", bus.k_o, k_exp);
    end else begin
      check("cfg_err_single_cycle", bus.cfg_err, 0);
    end
  endtask

  // Called at a negedge with the request already driven; waits for the grant.
  task automatic wait_grant(input logic [1:0] exp_rr, input exp_t e);
    int cyc;
    cyc = 0;
    while (bus.req_ready == 2'b00 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("grant_vector", bus.req_ready, exp_rr);
    if (bus.req_ready != 2'b00) sb_q.push_back(e);
  endtask

  task automatic finish_encode(input int k_exp);
    int   cyc;
    exp_t e;
    e.id = 1'b0;
    e.code = '0;
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("out_valid_latency", cyc, k_exp + 1);
    check("scoreboard_pending", sb_q.size(), 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check("out_code", bus.out_code, e.code);
    check("out_id", bus.out_id, e.id);
    step();
    @(negedge clk);
    check("out_valid_held", bus.out_valid, 1);
    check("out_code_held", bus.out_code, e.code);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_cleared", bus.out_valid, 0);
  endtask

  task automatic do_encode(input vec_t v);
    int   k_exp;
    exp_t e;
    k_exp  = ((1 << v.m) - 1) - int'(v.m);
    e.id   = v.id;
    e.code = v.code;
    step();
    bus.req_valid       = 2'b00;
    bus.req_valid[v.id] = 1'b1;
    bus.req_msg         = v.id ? {v.msg, {K_MAX{1'b0}}} : {{K_MAX{1'b0}}, v.msg};
    @(negedge clk);
    wait_grant(v.id ? 2'b10 : 2'b01, e);
    finish_encode(k_exp);
  endtask

  task automatic rr_test();
    int   grant_ids [4];
    int   grant_cyc [4];
    int   ng, cyc;
    exp_t e;
    ng  = 0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      grant_ids[i] = -1;
      grant_cyc[i] = -100;
    end
    step();
    bus.req_msg   = {11'h00F, 11'h005};
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b1;
    while ((ng < 4 || sb_q.size() != 0) && cyc < 100) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00 && ng < 4) begin
        check("rr_grant_onehot", $countones(bus.req_ready), 1);
        grant_ids[ng] = bus.req_ready[1] ? 1 : 0;
        grant_cyc[ng] = cyc;
        e.id   = ng[0];
        e.code = ng[0] ? 16'h00FF : 16'h0055;
        sb_q.push_back(e);
        ng++;
      end
      if (bus.out_valid) begin
        check("rr_scoreboard_pending", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("rr_out_code", bus.out_code, e.code);
          check("rr_out_id", bus.out_id, e.id);
        end
      end
      step();
      if (ng == 4) bus.req_valid = 2'b00;
      cyc++;
    end
    check("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) check("rr_grant_order", grant_ids[i], i % 2);
    for (int i = 1; i < 4; i++) check("rr_grant_interval", grant_cyc[i] - grant_cyc[i-1], 7);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int   cyc;
    bit   seen;
    logic [MW-1:0] cur_m;
    exp_t e;

    vecs[0]  = '{3'd3, 1'b0, 11'h001, 16'h00E1};
    vecs[1]  = '{3'd3, 1'b0, 11'h005, 16'h0055};
    vecs[2]  = '{3'd3, 1'b0, 11'h00F, 16'h00FF};
    vecs[3]  = '{3'd3, 1'b0, 11'h002, 16'h00D2};
    vecs[4]  = '{3'd3, 1'b1, 11'h004, 16'h00B4};
    vecs[5]  = '{3'd3, 1'b1, 11'h008, 16'h0078};
    vecs[6]  = '{3'd3, 1'b1, 11'h013, 16'h0033};
    vecs[7]  = '{3'd4, 1'b0, 11'h001, 16'hE001};
    vecs[8]  = '{3'd4, 1'b1, 11'h000, 16'h0000};
    vecs[9]  = '{3'd4, 1'b0, 11'h400, 16'hFC00};
    vecs[10] = '{3'd4, 1'b1, 11'h002, 16'hD002};
    vecs[11] = '{3'd2, 1'b0, 11'h001, 16'h000F};
    vecs[12] = '{3'd2, 1'b1, 11'h7FE, 16'h0000};
    vecs[13] = '{3'd2, 1'b0, 11'h7FF, 16'h000F};

    reset         = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_m     = '0;
    bus.req_valid = 2'b00;
    bus.req_msg   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_cfg_ready", bus.cfg_ready, 0);
    check("reset_cfg_done", bus.cfg_done, 0);
    check("reset_n_o", bus.n_o, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_req_ready", bus.req_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cfg_ready", bus.cfg_ready, 1);

    // Illegal m and requests while unconfigured.
    do_config(3'd1, 1'b0);
    check("idle_n_after_illegal", bus.n_o, 0);
    step();
    bus.req_valid = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) seen = 1'b1;
    end
    check("idle_no_grant", seen, 0);
    step();
    bus.req_valid = 2'b00;

    cur_m = '0;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].m != cur_m) begin
        do_config(vecs[i].m, 1'b1);
        cur_m = vecs[i].m;
      end
      do_encode(vecs[i]);
    end

    // Illegal reconfiguration in READY leaves the m=3 table intact.
    do_config(3'd3, 1'b1);
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_m     = 3'd5;
    @(negedge clk);
    check("ready_cfg_err", bus.cfg_err, 1);
    step();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    check("ready_n_kept", bus.n_o, 7);
    check("ready_k_kept", bus.k_o, 4);
    check("ready_done_kept", bus.cfg_done, 1);
    do_encode('{3'd3, 1'b0, 11'h00F, 16'h00FF});

    // Config and requests together: config wins, requests wait out the rebuild.
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_m     = 3'd3;
    bus.req_valid = 2'b11;
    bus.req_msg   = {11'h008, 11'h001};
    @(negedge clk);
    check("cfg_wins_no_grant", bus.req_ready, 0);
    check("cfg_wins_ready", bus.cfg_ready, 1);
    step();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    check("rebuild_started", bus.cfg_done, 0);
    cyc  = 1;
    seen = 1'b0;
    while (!bus.cfg_done && cyc < 40) begin
      if (bus.req_ready != 2'b00) seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("no_grant_in_build", seen, 0);
    check("rebuild_latency", cyc, 8);
    e.id   = 1'b1;
    e.code = 16'h0078;
    wait_grant(2'b10, e);
    finish_encode(4);

    // Asynchronous reset in the middle of an encode with the sink stalled.
    step();
    bus.req_valid = 2'b01;
    bus.req_msg   = {11'h000, 11'h00F};
    @(negedge clk);
    e.id   = 1'b0;
    e.code = 16'h00FF;
    wait_grant(2'b01, e);
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    step();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_cfg_ready", bus.cfg_ready, 0);
    check("midreset_cfg_done", bus.cfg_done, 0);
    check("midreset_n_o", bus.n_o, 0);
    check("midreset_k_o", bus.k_o, 0);
    check("midreset_out_code", bus.out_code, 0);
    sb_q.delete();
    step();
    check("midreset_hold_cfg_ready", bus.cfg_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    bus.req_valid = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) seen = 1'b1;
    end
    check("postreset_no_grant", seen, 0);
    check("postreset_cfg_ready", bus.cfg_ready, 1);
    check("postreset_cfg_done", bus.cfg_done, 0);
    step();
    bus.req_valid = 2'b00;

    // Fresh configuration, then two requesters contending with the sink always ready.
    do_config(3'd3, 1'b1);
    rr_test();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
